ece571f23_g5_aes_addroundkey: RTL and testbench

Sequential AddRoundKey stage of the iterative AES-128 encryption datapath. It consumes each 128-bit state from the MixColumns stage, or the plaintext or final-round ShiftRows state when MixColumns is bypassed, and XORs it with the current round key. Round keys are generated on the fly, one expansion step per accepted state, from a loaded cipher key. Results are registered and returned to the round loop, or to the ciphertext output, through a valid/ready handshake.

---
 rtl/ece571f23_g5_aes_addroundkey_if.sv | 23 ++
 rtl/ece571f23_g5_aes_addroundkey.sv | 107 ++++++++++
 tb/tb_ece571f23_g5_aes_addroundkey.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ece571f23_g5_aes_addroundkey_if.sv
// rtl/ece571f23_g5_aes_addroundkey_if.sv - key load, state input and result handshake bundle for AddRoundKey
interface ece571f23_g5_aes_addroundkey_if;
    logic         key_load;
    logic [127:0] key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out;
    logic [3:0]   round;
    logic         last;

    modport master (
        output key_load, key, in_valid, in, out_ready,
        input  in_ready, out_valid, out, round, last
    );

    modport slave (
        input  key_load, key, in_valid, in, out_ready,
        output in_ready, out_valid, out, round, last
    );
endinterface

// File: rtl/ece571f23_g5_aes_addroundkey.sv
// rtl/ece571f23_g5_aes_addroundkey.sv - AES-128 AddRoundKey stage with on-the-fly key expansion
module ece571f23_g5_aes_addroundkey (
    input  logic clk,
    input  logic rst_n,
    ece571f23_g5_aes_addroundkey_if.slave bus
);
    logic [127:0] key_q;
    logic [127:0] rk_q;
    logic [3:0]   round_q;
    logic         key_valid;
    logic         accept;
    logic [7:0]   rcon;
    logic [31:0]  rot;
    logic [31:0]  t;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic [127:0] rk_next;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] p;
        p = gf_mul(b, b);
        r = p;
        for (int i = 0; i < 6; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    always_comb begin
        rcon = 8'h00;
        case (round_q)
            4'd0: rcon = 8'h01;
            4'd1: rcon = 8'h02;
            4'd2: rcon = 8'h04;
            4'd3: rcon = 8'h08;
            4'd4: rcon = 8'h10;
            4'd5: rcon = 8'h20;
            4'd6: rcon = 8'h40;
            4'd7: rcon = 8'h80;
            4'd8: rcon = 8'h1b;
            4'd9: rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        rot = {rk_q[23:0], rk_q[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])}
              ^ {rcon, 24'h000000};
        w0n = rk_q[127:96] ^ t;
        w1n = rk_q[95:64] ^ w0n;
        w2n = rk_q[63:32] ^ w1n;
        w3n = rk_q[31:0] ^ w2n;
        rk_next = {w0n, w1n, w2n, w3n};
    end

    assign bus.in_ready = key_valid & ~bus.key_load & (~bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign bus.round    = round_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q         <= '0;
            rk_q          <= '0;
            round_q       <= '0;
            key_valid     <= 1'b0;
            bus.out       <= '0;
            bus.out_valid <= 1'b0;
            bus.last      <= 1'b0;
        end else if (bus.key_load) begin
            key_q         <= bus.key;
            rk_q          <= bus.key;
            round_q       <= '0;
            key_valid     <= 1'b1;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            bus.out       <= bus.in ^ rk_q;
            bus.out_valid <= 1'b1;
            bus.last      <= (round_q == 4'd10);
            // After round key 10 rewind to the cipher key so the next block needs no reload
            if (round_q == 4'd10) begin
                round_q <= '0;
                rk_q    <= key_q;
            end else begin
                round_q <= round_q + 4'd1;
                rk_q    <= rk_next;
            end
        end else if (bus.out_valid && bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ece571f23_g5_aes_addroundkey.sv
// tb/tb_ece571f23_g5_aes_addroundkey.sv - scoreboard bench for the AES AddRoundKey stage
module tb_ece571f23_g5_aes_addroundkey;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;

    ece571f23_g5_aes_addroundkey_if bus();

    ece571f23_g5_aes_addroundkey dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIPS-197 A.1 and C.1 round keys
    function automatic logic [127:0] exp_rk(input int kid, input int r);
        if (kid == 0) begin
            case (r)
                0:  return 128'h2b7e151628aed2a6abf7158809cf4f3c;
                1:  return 128'ha0fafe1788542cb123a339392a6c7605;
                2:  return 128'hf2c295f27a96b9435935807a7359f67f;
                3:  return 128'h3d80477d4716fe3e1e237e446d7a883b;
                4:  return 128'hef44a541a8525b7fb671253bdb0bad00;
                5:  return 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
                6:  return 128'h6d88a37a110b3efddbf98641ca0093fd;
                7:  return 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
                8:  return 128'head27321b58dbad2312bf5607f8d292f;
                9:  return 128'hac7766f319fadc2128d12941575c006e;
                default: return 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
            endcase
        end
        if (r == 0) return KEY_B;
        return 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    endfunction

    logic [128:0] sb_q[$];
    logic [128:0] sb_e;
    int           m_round;
    int           m_kid;

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            m_round = 0;
        end else if (bus.key_load) begin
            sb_q.delete();
            m_round = 0;
            m_kid = (bus.key == KEY_A) ? 0 : 1;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: out=%h with no expected beat", bus.out);
                end else begin
                    sb_e = sb_q.pop_front();
                    if ({bus.last, bus.out} !== sb_e) begin
                        errors++;
                        $display("FAIL sb_beat: got last=%b out=%h expected last=%b out=%h",
                                 bus.last, bus.out, sb_e[128], sb_e[127:0]);
                    end
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back({(m_round == 10), bus.in ^ exp_rk(m_kid, m_round)});
                m_round = (m_round == 10) ? 0 : m_round + 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.key_load = 1'b1;
        bus.key      = k;
        tick();
        bus.key_load = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b1;
        bus.in = 128'h1;
        bus.out_ready = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.last, bus.round, bus.out} !== '0) begin
            errors++;
            $display("FAIL reset_vals: got ov=%b ir=%b last=%b round=%0d out=%h required all zero",
                     bus.out_valid, bus.in_ready, bus.last, bus.round, bus.out);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL prekey_idle: got ir=%b ov=%b required 0 0", bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_fips_first();
        bus.key_load = 1'b1;
        bus.key = KEY_A;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL load_ready: got in_ready=%b required 0", bus.in_ready);
        end
        tick();
        bus.key_load = 1'b0;
        bus.in_valid = 1'b1;
        bus.in = 128'h3243f6a8885a308d313198a2e0370734;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== 128'h193de3bea0f4e22b9ac68d2ae9f84808 || bus.last !== 1'b0 || bus.round !== 4'd1) begin
            errors++;
            $display("FAIL fips_first: got out=%h last=%b round=%0d required 193de3bea0f4e22b9ac68d2ae9f84808 0 1",
                     bus.out, bus.last, bus.round);
        end
        tick();
    endtask

    task automatic test_key_schedule();
        load_key(KEY_A);
        bus.in_valid = 1'b1;
        bus.in = '0;
        for (int i = 0; i < 11; i++) tick();
        checks++;
        if (bus.out !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6 || bus.last !== 1'b1 || bus.round !== 4'd0) begin
            errors++;
            $display("FAIL ks_round10: got out=%h last=%b round=%0d required d014f9a8c9ee2589e13f0cc8b6630ca6 1 0",
                     bus.out, bus.last, bus.round);
        end
        tick();
        checks++;
        if (bus.out !== KEY_A || bus.last !== 1'b0 || bus.round !== 4'd1) begin
            errors++;
            $display("FAIL ks_wrap: got out=%h last=%b round=%0d required %h 0 1",
                     bus.out, bus.last, bus.round, KEY_A);
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        logic [127:0] out_h;
        logic         last_h;
        logic [3:0]   round_h;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in = {$urandom, $urandom, $urandom, $urandom};
        tick();
        bus.in = {$urandom, $urandom, $urandom, $urandom};
        out_h = bus.out;
        last_h = bus.last;
        round_h = bus.round;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out !== out_h || bus.last !== last_h || bus.round !== round_h
                || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold: got out=%h last=%b round=%0d ir=%b ov=%b required %h %b %0d 0 1",
                         bus.out, bus.last, bus.round, bus.in_ready, bus.out_valid, out_h, last_h, round_h);
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            bus.in = {$urandom, $urandom, $urandom, $urandom};
            checks++;
            if (bus.round !== 4'((int'(round_h) + i) % 11)) begin
                errors++;
                $display("FAIL bp_round: got round=%0d required %0d", bus.round, (int'(round_h) + i) % 11);
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_key_load_mid();
        load_key(KEY_A);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        checks++;
        if (bus.round !== 4'd5 || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL klm_pre: got round=%0d ov=%b required 5 1", bus.round, bus.out_valid);
        end
        bus.key_load = 1'b1;
        bus.key = KEY_B;
        tick();
        bus.key_load = 1'b0;
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.round !== 4'd0) begin
            errors++;
            $display("FAIL klm_load: got ov=%b round=%0d required 0 0", bus.out_valid, bus.round);
        end
        bus.in_valid = 1'b1;
        bus.in = '0;
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.out !== KEY_B || bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL klm_beat: got out=%h ov=%b required %h 1", bus.out, bus.out_valid, KEY_B);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        load_key(KEY_A);
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.last, bus.round, bus.out} !== '0) begin
            errors++;
            $display("FAIL async_reset: got ov=%b ir=%b last=%b round=%0d out=%h required all zero",
                     bus.out_valid, bus.in_ready, bus.last, bus.round, bus.out);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: got ir=%b ov=%b required 0 0", bus.in_ready, bus.out_valid);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        m_round = 0;
        m_kid = 0;
        rst_n = 1'b0;
        bus.key_load = 1'b0;
        bus.key = '0;
        bus.in_valid = 1'b0;
        bus.in = '0;
        bus.out_ready = 1'b1;
        test_reset();
        test_fips_first();
        test_key_schedule();
        test_backpressure();
        test_key_load_mid();
        test_reset_mid();
        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending beats required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
